rv3n_stage_dc: RTL and testbench

- Decode-stage bundle buffer between the fetch stage (`if`) and the issue/ID stage.
- Accepts PNUM-lane instruction bundles and sends each lane's instruction word through the external combinational decoder.
- Kills lanes that follow a taken control transfer, and optionally compacts the surviving lanes.
- Queues bundles in a 2-entry FIFO and presents them to ID through the `dc2id_*` / `id2dc_ready` handshake.

---
 rtl/rv3n_stage_dc.sv | 194 +++++++++++++++++++
 tb/tb_rv3n_stage_dc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv3n_stage_dc.sv
// rv3n decode-stage bundle buffer: kills lanes behind a taken control transfer and queues bundles for ID.
// Optional build macro DC_COMPACT_EN packs surviving lanes toward lane 0.
module rv3n_stage_dc #(
    parameter int PNUM   = 3,
    parameter int XLEN   = 32,
    parameter int DC_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stage_dc_clear,
    output logic                   dc2if_ready,
    input  logic [PNUM-1:0]        if2dc_valid,
    input  logic [PNUM*XLEN-1:0]   if2dc_instr,
    input  logic [PNUM-1:0]        if2dc_predict,
    input  logic [PNUM*XLEN-1:0]   if2dc_pc,
    output logic [PNUM*XLEN-1:0]   dc2dec_instr,
    input  logic [PNUM*DC_LEN-1:0] dec2dc_arguments,
    input  logic                   id2dc_ready,
    output logic [PNUM-1:0]        dc2id_valid,
    output logic [PNUM*XLEN-1:0]   dc2id_instr,
    output logic [PNUM-1:0]        dc2id_predict,
    output logic [PNUM*DC_LEN-1:0] dc2id_arguments,
    output logic [PNUM*XLEN-1:0]   dc2id_pc
);

    localparam int DEPTH = 2;
    localparam int LW    = XLEN + 1 + DC_LEN + XLEN;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    // Lane payload layout: {instr, predict, arguments, pc}
    typedef logic [PNUM-1:0][LW-1:0] pay_t;

    function automatic logic is_term(input logic [DC_LEN-1:0] a, input logic p);
        return a[DC_LEN-1] | a[DC_LEN-2] | a[DC_LEN-3] | (a[DC_LEN-4] & p);
    endfunction

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    pay_t            in_pay_s;
    pay_t            proc_pay_s;
    logic [PNUM-1:0] kv_s;
    logic [PNUM-1:0] proc_v_s;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PNUM-1:0] mem_v_q [DEPTH];
    logic [PNUM-1:0] mem_v_d [DEPTH];
    pay_t            mem_pay_q [DEPTH];
    pay_t            mem_pay_d [DEPTH];
    logic [PNUM-1:0] out_v_q, out_v_d;
    pay_t            out_pay_q, out_pay_d;

    logic ready_s, accept_s, load_s, pop_s, bypass_s, push_s;

    assign dc2dec_instr = if2dc_instr;
    assign ready_s      = (count_q < CW'(DEPTH));
    assign accept_s     = ready_s & (|if2dc_valid);
    assign load_s       = id2dc_ready | ~(|out_v_q);
    assign pop_s        = load_s & (count_q != '0);
    assign bypass_s     = load_s & (count_q == '0) & accept_s;
    assign push_s       = accept_s & ~bypass_s;
    assign dc2if_ready  = ready_s;

    // Gather lanes and clear every valid lane behind the first terminator
    always_comb begin
        logic seen;
        seen     = 1'b0;
        in_pay_s = '0;
        kv_s     = '0;
        for (int j = 0; j < PNUM; j++) begin
            in_pay_s[j] = {if2dc_instr[j*XLEN +: XLEN], if2dc_predict[j],
                           dec2dc_arguments[j*DC_LEN +: DC_LEN], if2dc_pc[j*XLEN +: XLEN]};
            kv_s[j]     = if2dc_valid[j] & ~seen;
            if (kv_s[j] & is_term(dec2dc_arguments[j*DC_LEN +: DC_LEN], if2dc_predict[j])) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
        end
    end

`ifdef DC_COMPACT_EN
    localparam int IW = (PNUM > 1) ? $clog2(PNUM) : 1;
    localparam int SW = $clog2(PNUM + 1);

    // Pack surviving lanes toward lane 0; vacated lanes carry zero payload
    always_comb begin
        logic [SW-1:0] slot;
        slot       = '0;
        proc_v_s   = '0;
        proc_pay_s = '0;
        for (int j = 0; j < PNUM; j++) begin
            if (kv_s[j]) begin
                proc_v_s[slot[IW-1:0]]   = 1'b1;
                proc_pay_s[slot[IW-1:0]] = in_pay_s[j];
                slot                     = slot + SW'(1);
            end else begin
                slot = slot;
            end
        end
    end
`else
    // Lanes keep their positions; killed lanes keep their payload
    always_comb begin
        proc_v_s   = kv_s;
        proc_pay_s = in_pay_s;
    end
`endif

    // FIFO, pointer, count and output-register next state; clear wins over everything
    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        mem_v_d   = mem_v_q;
        mem_pay_d = mem_pay_q;
        out_v_d   = out_v_q;
        out_pay_d = out_pay_q;
        if (stage_dc_clear) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            out_v_d  = '0;
        end else begin
            if (load_s) begin
                if (pop_s) begin
                    out_v_d   = mem_v_q[rd_ptr_q];
                    out_pay_d = mem_pay_q[rd_ptr_q];
                    rd_ptr_d  = nxt_ptr(rd_ptr_q);
                end else if (accept_s) begin
                    out_v_d   = proc_v_s;
                    out_pay_d = proc_pay_s;
                end else begin
                    out_v_d = '0;
                end
            end else begin
                out_v_d = out_v_q;
            end
            if (push_s) begin
                mem_v_d[wr_ptr_q]   = proc_v_s;
                mem_pay_d[wr_ptr_q] = proc_pay_s;
                wr_ptr_d            = nxt_ptr(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            mem_v_q   <= '{default: '0};
            mem_pay_q <= '{default: '0};
            out_v_q   <= '0;
            out_pay_q <= '0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            mem_v_q   <= mem_v_d;
            mem_pay_q <= mem_pay_d;
            out_v_q   <= out_v_d;
            out_pay_q <= out_pay_d;
        end
    end

    // Split the output register back into the per-field ID buses
    always_comb begin
        dc2id_valid     = out_v_q;
        dc2id_instr     = '0;
        dc2id_predict   = '0;
        dc2id_arguments = '0;
        dc2id_pc        = '0;
        for (int j = 0; j < PNUM; j++) begin
            dc2id_instr[j*XLEN +: XLEN]       = out_pay_q[j][XLEN+DC_LEN+1 +: XLEN];
            dc2id_predict[j]                  = out_pay_q[j][XLEN+DC_LEN];
            dc2id_arguments[j*DC_LEN +: DC_LEN] = out_pay_q[j][XLEN +: DC_LEN];
            dc2id_pc[j*XLEN +: XLEN]          = out_pay_q[j][XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_rv3n_stage_dc.sv
// Scoreboard bench for rv3n_stage_dc: directed scenarios plus randomized traffic against a queue-based model.
module tb_rv3n_stage_dc;

    localparam int PNUM   = 3;
    localparam int XLEN   = 32;
    localparam int DC_LEN = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   stage_dc_clear;
    logic                   dc2if_ready;
    logic [PNUM-1:0]        if2dc_valid;
    logic [PNUM*XLEN-1:0]   if2dc_instr;
    logic [PNUM-1:0]        if2dc_predict;
    logic [PNUM*XLEN-1:0]   if2dc_pc;
    logic [PNUM*XLEN-1:0]   dc2dec_instr;
    logic [PNUM*DC_LEN-1:0] dec2dc_arguments;
    logic                   id2dc_ready;
    logic [PNUM-1:0]        dc2id_valid;
    logic [PNUM*XLEN-1:0]   dc2id_instr;
    logic [PNUM-1:0]        dc2id_predict;
    logic [PNUM*DC_LEN-1:0] dc2id_arguments;
    logic [PNUM*XLEN-1:0]   dc2id_pc;

    typedef struct packed {
        logic [PNUM-1:0]        v;
        logic [PNUM*XLEN-1:0]   instr;
        logic [PNUM-1:0]        pred;
        logic [PNUM*DC_LEN-1:0] args;
        logic [PNUM*XLEN-1:0]   pc;
    } bun_t;

    bun_t exp_q[$];
    int   occ     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    rv3n_stage_dc #(.PNUM(PNUM), .XLEN(XLEN), .DC_LEN(DC_LEN)) dut (
        .clk(clk), .rst(rst), .stage_dc_clear(stage_dc_clear), .dc2if_ready(dc2if_ready),
        .if2dc_valid(if2dc_valid), .if2dc_instr(if2dc_instr), .if2dc_predict(if2dc_predict),
        .if2dc_pc(if2dc_pc), .dc2dec_instr(dc2dec_instr), .dec2dc_arguments(dec2dc_arguments),
        .id2dc_ready(id2dc_ready), .dc2id_valid(dc2id_valid), .dc2id_instr(dc2id_instr),
        .dc2id_predict(dc2id_predict), .dc2id_arguments(dc2id_arguments), .dc2id_pc(dc2id_pc)
    );

    always #5 clk = ~clk;

    // Stand-in decoder: flag bits come from the top instruction bits
    function automatic logic [DC_LEN-1:0] decode(input logic [XLEN-1:0] i);
        logic [DC_LEN-1:0] a;
        a             = '0;
        a[DC_LEN-1]   = &i[31:29];
        a[DC_LEN-2]   = &i[28:26];
        a[DC_LEN-3]   = &i[25:23];
        a[DC_LEN-4]   = i[22];
        a[DC_LEN-5:0] = i[DC_LEN-5:0];
        return a;
    endfunction

    always_comb begin
        dec2dc_arguments = '0;
        for (int j = 0; j < PNUM; j++)
            dec2dc_arguments[j*DC_LEN +: DC_LEN] = decode(dc2dec_instr[j*XLEN +: XLEN]);
    end

    function automatic logic [XLEN-1:0] mk(input logic sup, input logic jalr, input logic jal,
                                           input logic jc, input logic [21:0] lo);
        return {{3{sup}}, {3{jalr}}, {3{jal}}, jc, lo};
    endfunction

    // Reference: find the first taken transfer, keep lanes up to it, optionally pack them
    function automatic bun_t model(input logic [PNUM-1:0] v, input logic [PNUM*XLEN-1:0] ins,
                                   input logic [PNUM-1:0] pr, input logic [PNUM*XLEN-1:0] pc);
        bun_t b;
        int stop;
        int keep[$];
        logic [DC_LEN-1:0] a;
        b    = '0;
        stop = PNUM;
        for (int j = 0; j < PNUM; j++) begin
            a = decode(ins[j*XLEN +: XLEN]);
            if (stop == PNUM && v[j] &&
                (a[DC_LEN-1] || a[DC_LEN-2] || a[DC_LEN-3] || (a[DC_LEN-4] && pr[j])))
                stop = j;
        end
        for (int j = 0; j < PNUM; j++)
            if (v[j] && j <= stop) keep.push_back(j);
`ifdef DC_COMPACT_EN
        foreach (keep[k]) begin
            int j;
            j = keep[k];
            b.v[k]                       = 1'b1;
            b.instr[k*XLEN +: XLEN]      = ins[j*XLEN +: XLEN];
            b.pred[k]                    = pr[j];
            b.args[k*DC_LEN +: DC_LEN]   = decode(ins[j*XLEN +: XLEN]);
            b.pc[k*XLEN +: XLEN]         = pc[j*XLEN +: XLEN];
        end
`else
        b.instr = ins;
        b.pred  = pr;
        b.pc    = pc;
        for (int j = 0; j < PNUM; j++)
            b.args[j*DC_LEN +: DC_LEN] = decode(ins[j*XLEN +: XLEN]);
        foreach (keep[k]) b.v[keep[k]] = 1'b1;
`endif
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; the expected bundle is queued when it will be accepted
    task automatic cyc(input logic [PNUM-1:0] v, input logic [PNUM*XLEN-1:0] ins,
                       input logic [PNUM-1:0] pr, input logic [PNUM*XLEN-1:0] pc,
                       input logic idr, input logic clr);
        if2dc_valid    = v;
        if2dc_instr    = ins;
        if2dc_predict  = pr;
        if2dc_pc       = pc;
        id2dc_ready    = idr;
        stage_dc_clear = clr;
        if (!clr && occ <= 2 && v != '0) exp_q.push_back(model(v, ins, pr, pc));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic idr);
        cyc('0, '0, '0, '0, idr, 1'b0);
    endtask

    // Monitor: checks what the DUT presents, then retires/flushes model entries
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            occ = 0;
        end else begin
            chk("ready", dc2if_ready, occ <= 2);
            chk("dec_instr", dc2dec_instr, if2dc_instr);
            if (occ == 0) chk("idle_valid", dc2id_valid, '0);
            else chk("bundle", {dc2id_valid, dc2id_instr, dc2id_predict, dc2id_arguments, dc2id_pc},
                     exp_q[0]);
            if (stage_dc_clear) exp_q.delete();
            else if (id2dc_ready && occ > 0) void'(exp_q.pop_front());
            occ = exp_q.size();
        end
    end

    logic [PNUM*XLEN-1:0] pl, pa, pb, pc3, r_ins, r_pc;
    logic [PNUM-1:0]      r_v, r_pr;

    initial begin
        if2dc_valid = '0; if2dc_instr = '0; if2dc_predict = '0; if2dc_pc = '0;
        id2dc_ready = 1'b0; stage_dc_clear = 1'b0;
        pl  = {mk(0, 0, 0, 0, 22'h002000), mk(0, 0, 0, 0, 22'h001000), mk(0, 0, 0, 0, 22'h003000)};
        pa  = {32'h118, 32'h114, 32'h110};
        pb  = {32'h128, 32'h124, 32'h120};
        pc3 = {32'h138, 32'h134, 32'h130};
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        chk("reset_valid", dc2id_valid, '0);
        chk("reset_ready", dc2if_ready, 1'b1);
        chk("reset_pc", dc2id_pc, '0);

        cyc(3'b111, pl, 3'b000, {32'h108, 32'h104, 32'h100}, 1'b1, 1'b0);
        chk("bypass_valid", dc2id_valid, 3'b111);
        chk("bypass_pc", dc2id_pc, {32'h108, 32'h104, 32'h100});
        chk("bypass_ready", dc2if_ready, 1'b1);
        idle(1'b1);

        cyc(3'b111, pl, 3'b000, pa, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pb, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pc3, 1'b0, 1'b0);
        chk("bp_ready_low", dc2if_ready, 1'b0);
        chk("bp_hold_a", dc2id_pc[XLEN-1:0], 32'h110);
        cyc(3'b111, pl, 3'b000, {32'h148, 32'h144, 32'h140}, 1'b0, 1'b0);
        chk("bp_still_a", dc2id_pc[XLEN-1:0], 32'h110);
        idle(1'b1);
        chk("bp_order_b", dc2id_pc[XLEN-1:0], 32'h120);
        chk("bp_ready_back", dc2if_ready, 1'b1);
        idle(1'b1);
        chk("bp_order_c", dc2id_pc[XLEN-1:0], 32'h130);
        idle(1'b1);

        cyc(3'b111, {mk(0, 0, 0, 0, 22'h10), mk(0, 0, 0, 0, 22'h20), mk(0, 0, 1, 0, 22'h30)},
            3'b000, pa, 1'b1, 1'b0);
        chk("kill_jal", dc2id_valid, 3'b001);
        cyc(3'b111, {mk(0, 0, 0, 0, 22'h10), mk(0, 0, 0, 1, 22'h20), mk(0, 0, 0, 0, 22'h30)},
            3'b010, pb, 1'b1, 1'b0);
        chk("kill_jcond", dc2id_valid, 3'b011);

        cyc(3'b110, pl, 3'b000, {32'h208, 32'h204, 32'h200}, 1'b1, 1'b0);
`ifdef DC_COMPACT_EN
        chk("compact_valid", dc2id_valid, 3'b011);
        chk("compact_pc", dc2id_pc[2*XLEN-1:0], {32'h208, 32'h204});
`else
        chk("nocompact_valid", dc2id_valid, 3'b110);
        chk("nocompact_pc", dc2id_pc[3*XLEN-1:XLEN], {32'h208, 32'h204});
`endif
        idle(1'b1);

        cyc(3'b111, pl, 3'b000, pa, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pb, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pc3, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pa, 1'b1, 1'b1);
        chk("clear_full_valid", dc2id_valid, '0);
        chk("clear_full_ready", dc2if_ready, 1'b1);
        cyc(3'b111, pl, 3'b000, pa, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pb, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pc3, 1'b0, 1'b1);
        chk("clear_accept_valid", dc2id_valid, '0);
        chk("clear_accept_ready", dc2if_ready, 1'b1);
        repeat (3) idle(1'b1);

        cyc(3'b111, pl, 3'b000, pa, 1'b0, 1'b0);
        cyc(3'b111, pl, 3'b000, pb, 1'b0, 1'b0);
        if2dc_valid = '0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", dc2id_valid, '0);
        chk("async_rst_ready", dc2if_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int n = 0; n < 400; n++) begin
            r_v  = 3'($urandom_range(0, 7));
            r_pr = 3'($urandom_range(0, 7));
            for (int j = 0; j < PNUM; j++) begin
                r_ins[j*XLEN +: XLEN] = mk($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                                          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                                          22'($urandom));
                r_pc[j*XLEN +: XLEN]  = $urandom;
            end
            cyc(r_v, r_ins, r_pr, r_pc, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        repeat (5) idle(1'b1);
        chk("drain_valid", dc2id_valid, '0);
        chk("drain_ready", dc2if_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
